// File: rtl/car_drive_pkg.sv
// Shared types and constants for the two-wheel drive controller.
package car_drive_pkg;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_FWD   = 2'd1,
    ST_LEFT  = 2'd2,
    ST_RIGHT = 2'd3
  } state_t;

  localparam logic [3:0] KEY_STOP  = 4'b1110;
  localparam logic [3:0] KEY_FWD   = 4'b1101;
  localparam logic [3:0] KEY_LEFT  = 4'b1011;
  localparam logic [3:0] KEY_RIGHT = 4'b0111;
  localparam logic [3:0] KEY_IDLE  = 4'b1111;

  function automatic logic [3:0] state_to_oh(input state_t s);
    logic [3:0] oh;
    oh    = 4'b0000;
    oh[s] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/pwm_ramp_channel.sv
// One wheel: duty ramp toward target, direction reversal through zero, glitch-free PWM.
module pwm_ramp_channel #(
  parameter int unsigned PWM_W     = 8,
  parameter int unsigned RAMP_STEP = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [PWM_W-1:0] pwm_cnt,
  input  logic             pwm_wrap,
  input  logic [PWM_W-1:0] target_duty,
  input  logic             target_dir,
  output logic             pwm,
  output logic             dir,
  output logic             busy
);

  localparam logic [PWM_W:0] STEP = (PWM_W+1)'(RAMP_STEP);

  logic [PWM_W-1:0] duty_q, duty_d;
  logic [PWM_W-1:0] active_q;
  logic             dir_q, dir_d;
  logic             pwm_q;
  logic [PWM_W:0]   duty_x, tgt_x;

  assign duty_x = {1'b0, duty_q};
  assign tgt_x  = {1'b0, target_duty};

  always_comb begin
    duty_d = duty_q;
    dir_d  = dir_q;
    if (tick) begin
      if (dir_q != target_dir) begin
        // Flip only once the wheel is really stopped at the H-bridge, not just ramped.
        if (duty_q == '0) begin
          if (active_q == '0) dir_d = target_dir;
        end else if (duty_x > STEP) begin
          duty_d = PWM_W'(duty_x - STEP);
        end else begin
          duty_d = '0;
        end
      end else if (duty_x < tgt_x) begin
        if (duty_x + STEP > tgt_x) duty_d = target_duty;
        else                       duty_d = PWM_W'(duty_x + STEP);
      end else if (duty_x > tgt_x) begin
        if (duty_x - tgt_x > STEP) duty_d = PWM_W'(duty_x - STEP);
        else                       duty_d = target_duty;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_q   <= '0;
      active_q <= '0;
      dir_q    <= 1'b1;
      pwm_q    <= 1'b0;
    end else begin
      duty_q <= duty_d;
      dir_q  <= dir_d;
      if (pwm_wrap) active_q <= duty_q;
      pwm_q <= (pwm_cnt < active_q);
    end
  end

  assign pwm  = pwm_q;
  assign dir  = dir_q;
  assign busy = (duty_q != target_duty) | (dir_q != target_dir);

endmodule

// File: rtl/car_drive_ctrl.sv
// Key debounce, STOP/FWD/LEFT/RIGHT FSM, ramp tick and PWM counter driving two wheel channels.
module car_drive_ctrl
  import car_drive_pkg::*;
#(
  parameter int unsigned PWM_W     = 8,
  parameter int unsigned DUTY_FWD  = 200,
  parameter int unsigned DUTY_TURN = 128,
  parameter int unsigned RAMP_STEP = 8,
  parameter int unsigned RAMP_DIV  = 1000,
  parameter int unsigned DEB_CYC   = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key,
  output logic       leftw,
  output logic       rightw,
  output logic       left_dir,
  output logic       right_dir,
  output logic [3:0] state_oh,
  output logic       ramp_busy
);

  localparam int unsigned TICK_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned DEB_W  = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(RAMP_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
  localparam logic [PWM_W-1:0]  CNT_LAST  = {{(PWM_W-1){1'b1}}, 1'b0};

  logic [3:0]        sync1_q, sync2_q;
  logic [DEB_W-1:0]  deb_cnt_q;
  state_t            state_q, state_d, code_state;
  logic              code_valid;
  logic [3:0]        state_oh_q;
  logic [TICK_W-1:0] tick_cnt_q;
  logic              tick;
  logic [PWM_W-1:0]  pwm_cnt_q;
  logic              pwm_wrap;
  logic [PWM_W-1:0]  tgt_duty;
  logic              tgt_dir_l, tgt_dir_r;
  logic              busy_l, busy_r;

  always_comb begin
    code_valid = 1'b1;
    code_state = ST_STOP;
    case (sync2_q)
      KEY_STOP:  code_state = ST_STOP;
      KEY_FWD:   code_state = ST_FWD;
      KEY_LEFT:  code_state = ST_LEFT;
      KEY_RIGHT: code_state = ST_RIGHT;
      default:   code_valid = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (deb_cnt_q == DEB_LAST && code_valid) state_d = code_state;
  end

  // sync1 != sync2 means the synchronised code changes on this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= KEY_IDLE;
      sync2_q    <= KEY_IDLE;
      deb_cnt_q  <= '0;
      state_q    <= ST_STOP;
      state_oh_q <= 4'b0001;
    end else begin
      sync1_q <= key;
      sync2_q <= sync1_q;
      if (sync1_q != sync2_q)     deb_cnt_q <= '0;
      else if (deb_cnt_q != DEB_LAST) deb_cnt_q <= deb_cnt_q + 1'b1;
      state_q    <= state_d;
      state_oh_q <= state_to_oh(state_d);
    end
  end

  assign tick     = (tick_cnt_q == TICK_LAST);
  assign pwm_wrap = (pwm_cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
      pwm_cnt_q  <= '0;
    end else begin
      tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
      pwm_cnt_q  <= pwm_wrap ? '0 : pwm_cnt_q + 1'b1;
    end
  end

  // STOP keeps each wheel's current direction so it only ramps down.
  always_comb begin
    tgt_duty  = '0;
    tgt_dir_l = left_dir;
    tgt_dir_r = right_dir;
    case (state_q)
      ST_FWD:   begin tgt_duty = PWM_W'(DUTY_FWD);  tgt_dir_l = 1'b1; tgt_dir_r = 1'b1; end
      ST_LEFT:  begin tgt_duty = PWM_W'(DUTY_TURN); tgt_dir_l = 1'b0; tgt_dir_r = 1'b1; end
      ST_RIGHT: begin tgt_duty = PWM_W'(DUTY_TURN); tgt_dir_l = 1'b1; tgt_dir_r = 1'b0; end
      default:  tgt_duty = '0;
    endcase
  end

  pwm_ramp_channel #(.PWM_W(PWM_W), .RAMP_STEP(RAMP_STEP)) u_left (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .pwm_cnt     (pwm_cnt_q),
    .pwm_wrap    (pwm_wrap),
    .target_duty (tgt_duty),
    .target_dir  (tgt_dir_l),
    .pwm         (leftw),
    .dir         (left_dir),
    .busy        (busy_l)
  );

  pwm_ramp_channel #(.PWM_W(PWM_W), .RAMP_STEP(RAMP_STEP)) u_right (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .pwm_cnt     (pwm_cnt_q),
    .pwm_wrap    (pwm_wrap),
    .target_duty (tgt_duty),
    .target_dir  (tgt_dir_r),
    .pwm         (rightw),
    .dir         (right_dir),
    .busy        (busy_r)
  );

  assign state_oh  = state_oh_q;
  assign ramp_busy = busy_l | busy_r;

endmodule
